instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage feeding the main control decoder and datapath.
//  Holds the PC and requests words from instruction memory over a req/ack handshake.
//  Latches the returned word into an instruction register and presents it with opcode[5:0] for decode.
//  Computes the next PC from sequential, branch or jump redirect when the datapath consumes the instruction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; bits[1:0] must be 0
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  rst_n          in   1   synchronous active-low reset, sampled on rising clk
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  byte address of requested word (= pc)
//  imem_ack       in   1   memory returns imem_rdata this cycle
//  imem_rdata     in   32  instruction word, valid only when imem_ack=1
//  stall          in   1   datapath not ready; hold current instruction
//  branch_taken   in   1   redirect to branch_target on consume
//  branch_target  in   32  branch destination byte address
//  jump           in   1   redirect to jump_target on consume; overrides branch
//  jump_target    in   32  jump destination byte address
//  instr          out  32  instruction register contents
//  opcode         out  6   instr[31:26], drives control decoder
//  instr_valid    out  1   instr/opcode/pc are valid for decode
//  pc             out  32  address of the instruction in instr
//  pc_plus4       out  32  pc + 4, modulo 2^32
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_PC, instr=0, state=IDLE; so imem_req=0, instr_valid=0, opcode=0.
//    Reset overrides everything, including mid-handshake; a pending ack is discarded.
//  - FSM states: IDLE, FETCH, VALID.
//    IDLE  -> FETCH unconditionally on next edge (after rst_n=1).
//    FETCH: imem_req=1, imem_addr=pc. On edge with imem_ack=1: instr<=imem_rdata, -> VALID.
//           imem_ack=0: stay FETCH, req held, addr stable.
//    VALID: instr_valid=1. stall=1: hold all state. stall=0: pc<=next_pc, -> FETCH.
//  - imem_req and instr_valid decode from state only; never both high.
//  - imem_ack ignored outside FETCH; stall/branch/jump ignored outside VALID.
//  - next_pc priority: jump -> {jump_target[31:2],2'b00};
//    else branch_taken -> {branch_target[31:2],2'b00}; else pc_plus4.
//  - Low two address bits always forced 0; pc never misaligned.
//  - Wrap-around: pc=32'hFFFF_FFFC, sequential -> pc becomes 32'h0000_0000.
//  - Latency: req one cycle after reset release; instr_valid the cycle after ack;
//    best-case throughput one instruction per 2 cycles (ack same cycle as req, no stall).
//  - instr and pc are registered and stable for the whole VALID period.
// TESTING
//  1. Reset hold then release, imem_ack tied 1, rdata=32'h8C01_0004, stall=0
//     -> req cycle 1 addr 0, valid cycle 2 opcode=6'd35, next addr 4.
//  2. Ack delayed 3 cycles in FETCH -> req/addr held constant 3 cycles, instr captured only on ack edge.
//  3. stall=1 for 4 cycles in VALID -> instr, pc, instr_valid unchanged; no req issued.
//  4. VALID pc=0x10, branch_taken=1 target=0x40 -> next addr 0x40;
//     jump=1 and branch_taken=1 together, jump_target=0x80 -> next addr 0x80;
//     target=0x43 -> addr 0x40.
//  5. RESET_PC=32'hFFFF_FFFC, sequential consume -> next imem_addr=0x0.
//  6. rst_n=0 during FETCH with imem_ack=1 the same edge
//     -> instr stays 0, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and holds the returned instruction for decode until the datapath consumes it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;

    assign pc_plus4    = pc + 32'd4;
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == VALID);
    assign imem_addr   = pc;
    assign opcode      = instr[31:26];

    // Jump wins over branch; redirect targets are word-aligned by dropping bits [1:0].
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {jump_target[31:2], 2'b00};
        end else if (branch_taken) begin
            next_pc = {branch_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= {RESET_PC[31:2], 2'b00};
            instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory/datapath driver pushes expected fetch
// addresses and instructions, and a negedge monitor pops and compares them.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    // Second instance starting just below the top of the address space.
    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b1;
    logic [31:0] rdata2 = 32'h0000_0000;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] brt2 = 32'h0000_0000;
    logic        jmp2 = 1'b0;
    logic [31:0] jt2 = 32'h0000_0000;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] pcp4_2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] addrQ[$];
    exp_t        instrQ[$];
    logic [31:0] expPc;
    logic [31:0] heldInstr = 32'h0;
    logic [31:0] curAddr = 32'h0;
    exp_t        curInstr;
    logic        prevReq = 1'b0;
    logic        prevValid = 1'b0;
    logic        checking = 1'b0;
    logic [31:0] exp2 = WRAP_PC;
    logic        prevReq2 = 1'b0;
    int          fetches2 = 0;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    instr_fetch #(.RESET_PC(WRAP_PC)) dutWrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .stall(stall2),
        .branch_taken(br2), .branch_target(brt2),
        .jump(jmp2), .jump_target(jt2),
        .instr(instr2), .opcode(opcode2), .instr_valid(valid2),
        .pc(pc2), .pc_plus4(pcp4_2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares whatever the DUT is presenting against the head of the scoreboard.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("exclusiveReqValid", {31'b0, imem_req & instr_valid}, 32'h0);
            if (imem_req === 1'b1) begin
                if (!prevReq) begin
                    if (addrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL addrQueue actual=empty expected=entry at %0t", $time);
                    end else begin
                        curAddr = addrQ.pop_front();
                    end
                end
                checkOutput("imemAddr", imem_addr, curAddr);
                checkOutput("instrHeldInFetch", instr, heldInstr);
            end
            if (instr_valid === 1'b1) begin
                if (!prevValid) begin
                    if (instrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL instrQueue actual=empty expected=entry at %0t", $time);
                    end else begin
                        curInstr  = instrQ.pop_front();
                        heldInstr = curInstr.word;
                    end
                end
                checkOutput("instr", instr, curInstr.word);
                checkOutput("opcode", {26'b0, opcode}, {26'b0, curInstr.word[31:26]});
                checkOutput("pc", pc, curInstr.pc);
                checkOutput("pcPlus4", pc_plus4, curInstr.pc + 32'd4);
            end
        end
        prevReq   = (imem_req === 1'b1);
        prevValid = (instr_valid === 1'b1);
    end

    // Wrap instance model: fetch addresses ascend by 4 from its reset PC, modulo 2^32.
    always @(posedge clk) begin
        if (!rst_n) exp2 = WRAP_PC;
    end

    always @(negedge clk) begin
        if (checking && req2 === 1'b1 && !prevReq2) begin
            checkOutput("wrapAddr", addr2, exp2);
            exp2 = exp2 + 32'd4;
            fetches2++;
        end
        if (checking && valid2 === 1'b1) begin
            checkOutput("wrapPc", pc2, exp2 - 32'd4);
            checkOutput("wrapPcPlus4", pcp4_2, exp2);
        end
        prevReq2 = (req2 === 1'b1);
    end

    task automatic waitReq();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL reqTimeout actual=%b expected=1 at %0t", imem_req, $time);
        end
    endtask

    task automatic applyReset(input int n, input logic ackDuring);
        rst_n      = 1'b0;
        imem_ack   = ackDuring;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        stall    = 1'b0;
        addrQ.delete();
        instrQ.delete();
        addrQ.push_back(RESET_PC);
        expPc     = RESET_PC;
        heldInstr = 32'h0;
        checkOutput("resetReq", {31'b0, imem_req}, 32'h0);
        checkOutput("resetValid", {31'b0, instr_valid}, 32'h0);
        checkOutput("resetInstr", instr, 32'h0);
        checkOutput("resetOpcode", {26'b0, opcode}, 32'h0);
        checkOutput("resetPc", pc, RESET_PC);
        checkOutput("resetWrapPc", addr2, WRAP_PC);
        checkOutput("resetWrapReq", {31'b0, req2}, 32'h0);
        repeat (n - 1) @(negedge clk);
        checking = 1'b1;
        rst_n    = 1'b1;
    endtask

    // One instruction: serve the fetch after ackDelay cycles, stall, then consume with a redirect.
    task automatic applyStimulus(input logic [31:0] data, input int ackDelay, input int stallCycles,
                                 input logic br, input logic [31:0] brT,
                                 input logic jmp, input logic [31:0] jT);
        waitReq();
        for (int i = 0; i < ackDelay; i++) begin
            imem_ack      = 1'b0;
            imem_rdata    = $urandom;
            stall         = 1'($urandom_range(0, 1));
            branch_taken  = 1'($urandom_range(0, 1));
            jump          = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            jump_target   = $urandom;
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        instrQ.push_back('{pc: expPc, word: data});
        @(negedge clk);
        checkOutput("validLatency", {31'b0, instr_valid}, 32'h1);
        for (int i = 0; i < stallCycles; i++) begin
            imem_ack      = 1'($urandom_range(0, 1));
            imem_rdata    = $urandom;
            stall         = 1'b1;
            branch_taken  = 1'($urandom_range(0, 1));
            jump          = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            jump_target   = $urandom;
            @(negedge clk);
        end
        imem_ack      = 1'($urandom_range(0, 1));
        imem_rdata    = $urandom;
        stall         = 1'b0;
        branch_taken  = br;
        branch_target = brT;
        jump          = jmp;
        jump_target   = jT;
        if (jmp)     expPc = jT & 32'hFFFF_FFFC;
        else if (br) expPc = brT & 32'hFFFF_FFFC;
        else         expPc = expPc + 32'd4;
        addrQ.push_back(expPc);
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        expPc = RESET_PC;
        @(negedge clk);
        applyReset(3, 1'b0);

        $display("[TB] sequential fetch with immediate ack");
        applyStimulus(32'h8C01_0004, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("lwOpcode", {26'b0, opcode}, 32'd35);
        checkOutput("nextAddr4", imem_addr, 32'h4);

        $display("[TB] delayed ack and stall hold");
        applyStimulus($urandom, 3, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus($urandom, 0, 4, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus($urandom, 1, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] branch, jump priority and alignment");
        applyStimulus($urandom, 0, 0, 1'b1, 32'h40, 1'b0, 32'h0);
        checkOutput("branchAddr", imem_addr, 32'h40);
        applyStimulus($urandom, 0, 0, 1'b1, 32'h200, 1'b1, 32'h80);
        checkOutput("jumpOverBranch", imem_addr, 32'h80);
        applyStimulus($urandom, 0, 0, 1'b1, 32'h43, 1'b0, 32'h0);
        checkOutput("alignedTarget", imem_addr, 32'h40);

        $display("[TB] reset during fetch with ack");
        waitReq();
        @(negedge clk);
        applyReset(2, 1'b1);
        applyStimulus($urandom, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 200; n++) begin
            applyStimulus($urandom, $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                          1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 60) == 0) applyReset(2, 1'($urandom_range(0, 1)));
        end
        applyStimulus($urandom, 0, 0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("jumpTopAligned", imem_addr, 32'hFFFF_FFFC);
        applyStimulus($urandom, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("sequentialWrap", imem_addr, 32'h0);

        checkOutput("wrapFetchCount", {31'b0, fetches2 > 10}, 32'h1);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
